// File: rtl/mix_pkg.sv
// Shared MIX definitions: word geometry and the memory-port state encoding
// used by the block mover, the sequencer and move_mem_port.
package mix_pkg;

    localparam int MIX_WORD_W    = 31;    // sign + 5 bytes of 6 bits
    localparam int MIX_MEM_WORDS = 4000;
    localparam int ADDR_W        = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RDW  = 2'd2,
        WR   = 2'd3
    } port_state_e;

endpackage

// File: rtl/move_req_slot.sv
// One-deep holding register for a load or store request that arrives while
// the memory port is busy or is displaced by a same-cycle store.
module move_req_slot
    import mix_pkg::*;
#(
    parameter int WORD_W = MIX_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              push_store,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [WORD_W-1:0] push_data,
    output logic              valid,
    output logic              is_store,
    output logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= 1'b0;
            is_store <= 1'b0;
            addr     <= '0;
            data     <= '0;
        end else begin
            if (pop) begin
                valid <= 1'b0;
            end
            if (push) begin
                valid    <= 1'b1;
                is_store <= push_store;
                addr     <= push_addr;
                data     <= push_data;
            end
        end
    end

endmodule

// File: rtl/move_mem_port.sv
// Single-port RAM front end for the block mover: serialises loads and stores,
// owns the destination pointer. Optional macro MOVE_MEM_BOUNDS_CHECK_EN.
module move_mem_port
    import mix_pkg::*;
#(
    parameter int MEM_WORDS = MIX_MEM_WORDS,
    parameter int WORD_W    = MIX_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dst_load,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              load,
    input  logic              store,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              rvalid,
    output logic [ADDR_W-1:0] dst_out,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    port_state_e       state, state_nxt;
    logic [ADDR_W-1:0] dst_q, dst_nxt;
    logic [WORD_W-1:0] rdata_q;
    logic              rd_oob;

    logic              slot_valid, slot_store;
    logic [ADDR_W-1:0] slot_addr;
    logic [WORD_W-1:0] slot_data;
    logic              push, pop, push_store, ovf;

    logic              start, start_store, oob;
    logic [ADDR_W-1:0] start_addr;
    logic [WORD_W-1:0] start_data;

    move_req_slot #(.WORD_W(WORD_W)) u_slot (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_store (push_store),
        .push_addr  (src_addr),
        .push_data  (wdata),
        .valid      (slot_valid),
        .is_store   (slot_store),
        .addr       (slot_addr),
        .data       (slot_data)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the branches below can leave it unassigned (no latches).
        dst_nxt     = dst_q;
        start       = 1'b0;
        start_store = 1'b0;
        start_addr  = src_addr;
        start_data  = wdata;
        push        = 1'b0;
        pop         = 1'b0;
        push_store  = 1'b0;
        ovf         = 1'b0;
        oob         = 1'b0;
        state_nxt   = state;

        // A same-cycle dst_load overrides the post-write increment.
        if (dst_load) begin
            dst_nxt = dst_addr;
        end else if (state == WR) begin
            dst_nxt = dst_q + ADDR_W'(1);
        end

        // RD is the only state that cannot launch a new access next edge.
        if (state != RD && slot_valid) begin
            start       = 1'b1;
            pop         = 1'b1;
            start_store = slot_store;
            start_addr  = slot_addr;
            start_data  = slot_data;
            ovf         = load | store;
        end else if (state != RD && store) begin
            start       = 1'b1;
            start_store = 1'b1;
            push        = load;
        end else if (state != RD && load) begin
            start = 1'b1;
        end else if (load | store) begin
            push       = !slot_valid;
            push_store = store;
            ovf        = slot_valid | (load & store);
        end

        if (start_store) begin
            start_addr = dst_nxt;
        end

`ifdef MOVE_MEM_BOUNDS_CHECK_EN
        oob = start && (int'(start_addr) >= MEM_WORDS);
`endif

        if (start) begin
            state_nxt = start_store ? WR : RD;
        end else begin
            unique case (state)
                RD:      state_nxt = RDW;
                RDW, WR: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        rvalid = (state == RDW);
        rdata  = rdata_q;
        if (state == RDW) begin
            rdata = rd_oob ? '0 : mem_rdata;
        end
        dst_out = dst_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_q     <= '0;
            err       <= 1'b0;
            rdata_q   <= '0;
            rd_oob    <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            dst_q   <= dst_nxt;
            err     <= err | ovf | oob;
            rdata_q <= rdata;
            mem_we  <= start & start_store & ~oob;
            if (start) begin
                mem_addr <= start_addr;
                rd_oob   <= ~start_store & oob;
            end
            if (start && start_store) begin
                mem_wdata <= start_data;
            end
        end
    end

endmodule

// File: tb/tb_move_mem_port.sv
// Directed bench for move_mem_port with a synchronous RAM model; expected
// values are hand-derived constants or the preloaded RAM pattern.
module tb_move_mem_port;

    localparam int WW = 31;

    logic          clk = 1'b0;
    logic          reset;
    logic          dst_load, load, store;
    logic [11:0]   dst_addr, src_addr;
    logic [WW-1:0] wdata, rdata, mem_wdata, mem_rdata;
    logic          rvalid, err, mem_we;
    logic [11:0]   dst_out, mem_addr;
    logic [WW-1:0] ram [4096];

    int checks = 0;
    int errors = 0;

    move_mem_port dut (
        .clk       (clk),
        .reset     (reset),
        .dst_load  (dst_load),
        .dst_addr  (dst_addr),
        .load      (load),
        .store     (store),
        .src_addr  (src_addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .dst_out   (dst_out),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [WW-1:0] pat(int i);
        return WW'(i * 37 + 1000);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dst_load = 0; load = 0; store = 0;
        dst_addr = '0; src_addr = '0; wdata = '0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        cyc();
        reset = 0;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        cyc();
        checks++; if (rdata !== '0)     begin errors++; $display("FAIL reset_rdata: got %0h exp 0", rdata); end
        checks++; if (rvalid !== 1'b0)  begin errors++; $display("FAIL reset_rvalid: got %0b exp 0", rvalid); end
        checks++; if (dst_out !== '0)   begin errors++; $display("FAIL reset_dst_out: got %0d exp 0", dst_out); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %0b exp 0", err); end
        checks++; if (mem_we !== 1'b0)  begin errors++; $display("FAIL reset_mem_we: got %0b exp 0", mem_we); end
        checks++; if (mem_addr !== '0)  begin errors++; $display("FAIL reset_mem_addr: got %0d exp 0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %0h exp 0", mem_wdata); end
        reset = 0;
        cyc();
        checks++; if (rvalid !== 1'b0)  begin errors++; $display("FAIL post_reset_rvalid: got %0b exp 0", rvalid); end
    endtask

    task automatic test_copy();
        dst_load = 1; dst_addr = 12'd100;
        cyc();
        dst_load = 0;
        for (int k = 0; k < 3; k++) begin
            load = 1; src_addr = 12'(10 + k);
            cyc();
            load = 0;
            checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL copy_rd_rvalid[%0d]: got %0b exp 0", k, rvalid); end
            cyc();
            checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL copy_rvalid[%0d]: got %0b exp 1", k, rvalid); end
            checks++; if (rdata !== pat(10 + k)) begin errors++; $display("FAIL copy_rdata[%0d]: got %0h exp %0h", k, rdata, pat(10 + k)); end
            store = 1; wdata = pat(10 + k);
            cyc();
            store = 0;
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL copy_mem_we[%0d]: got %0b exp 1", k, mem_we); end
            checks++; if (mem_addr !== 12'(100 + k)) begin errors++; $display("FAIL copy_mem_addr[%0d]: got %0d exp %0d", k, mem_addr, 100 + k); end
            checks++; if (rdata !== pat(10 + k)) begin errors++; $display("FAIL copy_rdata_hold[%0d]: got %0h exp %0h", k, rdata, pat(10 + k)); end
            cyc();
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL copy_we_single[%0d]: got %0b exp 0", k, mem_we); end
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (ram[100 + k] !== pat(10 + k)) begin errors++; $display("FAIL copy_ram[%0d]: got %0h exp %0h", 100 + k, ram[100 + k], pat(10 + k)); end
        end
        checks++; if (dst_out !== 12'd103) begin errors++; $display("FAIL copy_dst_out: got %0d exp 103", dst_out); end
        checks++; if (err !== 1'b0)        begin errors++; $display("FAIL copy_err: got %0b exp 0", err); end
    endtask

    task automatic test_same_cycle();
        dst_load = 1; dst_addr = 12'd7;
        store = 1; wdata = 31'h1234_5678;
        load = 1; src_addr = 12'd5;
        cyc();
        idle_inputs();
        checks++; if (mem_we !== 1'b1)       begin errors++; $display("FAIL same_we: got %0b exp 1", mem_we); end
        checks++; if (mem_addr !== 12'd7)    begin errors++; $display("FAIL same_waddr: got %0d exp 7", mem_addr); end
        checks++; if (mem_wdata !== 31'h1234_5678) begin errors++; $display("FAIL same_wdata: got %0h exp 12345678", mem_wdata); end
        cyc();
        checks++; if (mem_we !== 1'b0)       begin errors++; $display("FAIL same_we_drop: got %0b exp 0", mem_we); end
        checks++; if (mem_addr !== 12'd5)    begin errors++; $display("FAIL same_raddr: got %0d exp 5", mem_addr); end
        checks++; if (dst_out !== 12'd8)     begin errors++; $display("FAIL same_dst: got %0d exp 8", dst_out); end
        checks++; if (rvalid !== 1'b0)       begin errors++; $display("FAIL same_early_rvalid: got %0b exp 0", rvalid); end
        cyc();
        checks++; if (rvalid !== 1'b1)       begin errors++; $display("FAIL same_rvalid: got %0b exp 1", rvalid); end
        checks++; if (rdata !== pat(5))      begin errors++; $display("FAIL same_rdata: got %0h exp %0h", rdata, pat(5)); end
        checks++; if (err !== 1'b0)          begin errors++; $display("FAIL same_err: got %0b exp 0", err); end
        cyc();
        checks++; if (ram[7] !== 31'h1234_5678) begin errors++; $display("FAIL same_ram7: got %0h exp 12345678", ram[7]); end
    endtask

    task automatic test_wrap();
        logic          exp_we, exp_err;
        logic [WW-1:0] exp_ram;
`ifdef MOVE_MEM_BOUNDS_CHECK_EN
        exp_we = 1'b0; exp_err = 1'b1; exp_ram = pat(4095);
`else
        exp_we = 1'b1; exp_err = 1'b0; exp_ram = 31'h0ABC_DEF0;
`endif
        dst_load = 1; dst_addr = 12'd4095;
        cyc();
        dst_load = 0; store = 1; wdata = 31'h0ABC_DEF0;
        cyc();
        store = 0;
        checks++; if (mem_we !== exp_we)      begin errors++; $display("FAIL wrap_we: got %0b exp %0b", mem_we, exp_we); end
        checks++; if (mem_addr !== 12'd4095)  begin errors++; $display("FAIL wrap_addr: got %0d exp 4095", mem_addr); end
        cyc();
        checks++; if (dst_out !== 12'd0)      begin errors++; $display("FAIL wrap_dst: got %0d exp 0", dst_out); end
        checks++; if (err !== exp_err)        begin errors++; $display("FAIL wrap_err: got %0b exp %0b", err, exp_err); end
        checks++; if (ram[4095] !== exp_ram)  begin errors++; $display("FAIL wrap_ram: got %0h exp %0h", ram[4095], exp_ram); end
    endtask

    task automatic test_bounds();
        logic          exp_err;
        logic [WW-1:0] exp_rd;
`ifdef MOVE_MEM_BOUNDS_CHECK_EN
        exp_err = 1'b1; exp_rd = '0;
`else
        exp_err = 1'b0; exp_rd = pat(4000);
`endif
        pulse_reset();
        load = 1; src_addr = 12'd3999;
        cyc();
        load = 0;
        cyc();
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL b3999_rvalid: got %0b exp 1", rvalid); end
        checks++; if (rdata !== '0)    begin errors++; $display("FAIL b3999_rdata: got %0h exp 0", rdata); end
        checks++; if (err !== 1'b0)    begin errors++; $display("FAIL b3999_err: got %0b exp 0", err); end
        cyc();
        load = 1; src_addr = 12'd4000;
        cyc();
        load = 0;
        cyc();
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL b4000_rvalid: got %0b exp 1", rvalid); end
        checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL b4000_rdata: got %0h exp %0h", rdata, exp_rd); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL b4000_err: got %0b exp %0b", err, exp_err); end
        cyc();
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        load = 1; src_addr = 12'd20;
        cyc();
        load = 0; store = 1; wdata = 31'h0000_0777;
        cyc();
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL b2b_err_queue: got %0b exp 0", err); end
        checks++; if (rvalid !== 1'b1)   begin errors++; $display("FAIL b2b_rvalid: got %0b exp 1", rvalid); end
        checks++; if (rdata !== pat(20)) begin errors++; $display("FAIL b2b_rdata: got %0h exp %0h", rdata, pat(20)); end
        store = 0; load = 1; src_addr = 12'd21;
        cyc();
        load = 0;
        checks++; if (err !== 1'b1)      begin errors++; $display("FAIL b2b_err_set: got %0b exp 1", err); end
        checks++; if (mem_we !== 1'b1)   begin errors++; $display("FAIL b2b_we: got %0b exp 1", mem_we); end
        checks++; if (mem_addr !== 12'd0) begin errors++; $display("FAIL b2b_waddr: got %0d exp 0", mem_addr); end
        checks++; if (mem_wdata !== 31'h0000_0777) begin errors++; $display("FAIL b2b_wdata: got %0h exp 777", mem_wdata); end
        repeat (4) cyc();
        checks++; if (err !== 1'b1)      begin errors++; $display("FAIL b2b_err_sticky: got %0b exp 1", err); end
        checks++; if (dst_out !== 12'd1) begin errors++; $display("FAIL b2b_dst: got %0d exp 1", dst_out); end
        checks++; if (rvalid !== 1'b0)   begin errors++; $display("FAIL b2b_dropped_load: got rvalid %0b exp 0", rvalid); end
    endtask

    task automatic test_reset_during_wr();
        dst_load = 1; dst_addr = 12'd50; store = 1; wdata = 31'h0000_5555;
        cyc();
        idle_inputs();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rwr_we_before: got %0b exp 1", mem_we); end
        reset = 1;
        #1;
        checks++; if (mem_we !== 1'b0)  begin errors++; $display("FAIL rwr_we_async: got %0b exp 0", mem_we); end
        checks++; if (mem_addr !== '0)  begin errors++; $display("FAIL rwr_addr: got %0d exp 0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL rwr_wdata: got %0h exp 0", mem_wdata); end
        checks++; if (dst_out !== '0)   begin errors++; $display("FAIL rwr_dst: got %0d exp 0", dst_out); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL rwr_err: got %0b exp 0", err); end
        checks++; if (rvalid !== 1'b0)  begin errors++; $display("FAIL rwr_rvalid: got %0b exp 0", rvalid); end
        checks++; if (rdata !== '0)     begin errors++; $display("FAIL rwr_rdata: got %0h exp 0", rdata); end
        cyc();
        reset = 0;
        cyc();
        checks++; if (ram[50] !== pat(50)) begin errors++; $display("FAIL rwr_ram_untouched: got %0h exp %0h", ram[50], pat(50)); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = pat(i);
        ram[3999] = '0;
        mem_rdata = '0;
        reset = 1;
        idle_inputs();
        #1;
        test_reset();
        test_copy();
        test_same_cycle();
        test_wrap();
        test_bounds();
        test_back_to_back();
        test_reset_during_wr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_mem_port.md
MOVE_MEM_PORT -- requirements
Module: move_mem_port

Interface
REQ-001 Parameter MEM_WORDS, default 4000, number of addressable memory words; valid addresses 0..MEM_WORDS-1.
REQ-002 Parameter WORD_W, default 31, width of a memory word (sign + 5 bytes of 6 bits).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 dst_load  input  1  one-cycle pulse; captures dst_addr as the destination pointer (rI1).
REQ-006 dst_addr  input  12  initial destination address.
REQ-007 load  input  1  read request from the block mover, for the word at src_addr.
REQ-008 store  input  1  write request from the block mover; writes wdata to the destination pointer.
REQ-009 src_addr  input  12  source address, sampled when load=1.
REQ-010 wdata  input  WORD_W  word to store, sampled when store=1.
REQ-011 rdata  output  WORD_W  read word returned to the mover.
REQ-012 rvalid  output  1  one-cycle pulse; rdata is valid in that cycle.
REQ-013 dst_out  output  12  current destination pointer, written back to rI1 by the sequencer.
REQ-014 err  output  1  sticky out-of-range flag.
REQ-015 mem_addr  output  12  single-port RAM address.
REQ-016 mem_we  output  1  RAM write enable.
REQ-017 mem_wdata  output  WORD_W  RAM write data.
REQ-018 mem_rdata  input  WORD_W  RAM read data, valid one cycle after the address is presented (synchronous RAM).

Function
REQ-019 The FSM SHALL have the states IDLE, RD (read address driven), RDW (capture read data) and WR (write driven).
REQ-020 In IDLE with load=1, the block SHALL drive mem_addr=src_addr and enter RD, so that rvalid=1 and rdata=mem_rdata two cycles after load.
REQ-021 In IDLE with store=1, the block SHALL drive mem_addr=dst_out, mem_we=1 and mem_wdata=wdata in the next cycle (WR), and then increment dst_out by 1.
REQ-022 If load and store are asserted in the same cycle, the write SHALL be served first; the load and src_addr SHALL be held in a one-deep pending register and served immediately after WR.
REQ-023 A load or store arriving while the port is busy SHALL be queued in the same one-deep pending slot; a second request while the slot is full SHALL set err and be dropped.
REQ-024 dst_load SHALL take priority over a store in the same cycle: the captured pointer SHALL be used for that store.
REQ-025 dst_out SHALL increment modulo 4096 (12-bit wrap).
REQ-026 rdata SHALL hold its last value between rvalid pulses.
REQ-027 mem_we SHALL never be high outside WR, and SHALL never be high for more than one cycle per store.

Reset
REQ-028 With reset=1, the block SHALL immediately force the FSM to IDLE, clear the pending slot, and set rdata=0, rvalid=0, dst_out=0, err=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-029 A reset during WR SHALL abort the write; mem_we SHALL be deasserted asynchronously.

Configuration
REQ-030 With MOVE_MEM_BOUNDS_CHECK_EN defined, any access with an address >= MEM_WORDS SHALL set err, suppress mem_we, return rdata=0 with rvalid, and still advance dst_out.
REQ-031 Without MOVE_MEM_BOUNDS_CHECK_EN, no address check SHALL be made; all 12-bit addresses SHALL be passed to the RAM unchanged, and err SHALL only flag pending-slot overflow.

Structure
REQ-032 The state encoding, WORD_W and MEM_WORDS defaults SHALL live in the shared MIX package used by the mover and sequencer.
REQ-033 The one-deep pending request slot SHALL be a sub-module named move_req_slot; everything else SHALL be in this module.

Verification
REQ-034 dst_load with dst_addr=100, then three load/store pairs from src_addr 10..12 -> RAM 100..102 equal RAM 10..12, dst_out=103, err=0.
REQ-035 load and store in the same cycle (src_addr=5, dst=7) -> write to 7 first, then rvalid with RAM[5] three cycles after the request, no err.
REQ-036 dst_addr=4095, one store -> dst_out wraps to 0; with the bounds macro defined: err=1 and no mem_we; without it: write to 4095.
REQ-037 Three back-to-back requests while busy -> the third sets err=1, and err stays 1 until reset.
REQ-038 Assert reset during WR -> mem_we drops in the same cycle, and all outputs equal their REQ-028 values.
REQ-039 load at src_addr=3999 with the bounds macro defined -> rvalid with rdata=0 and err=0; at 4000 -> err=1.
